// File: rtl/mips_data_bus_bridge.sv
// Bridges the CPU's combinational-read data port onto a registered, waitrequest-style bus.
// Optional access timeout is compiled in with `define MIPS_DATA_BRIDGE_TIMEOUT_EN.
module mips_data_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_address,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_writedata,
    output logic [31:0] cpu_readdata,
    output logic        cpu_clk_enable,
    output logic [31:0] bus_address,
    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] bus_writedata,
    input  logic        bus_waitrequest,
    input  logic [31:0] bus_readdata,
    output logic        bus_error
);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] address_nx;
    logic [31:0] writedata_nx;
    logic        read_nx;
    logic        write_nx;
    logic [31:0] rdata_buf;
    logic [31:0] rdata_nx;
    logic        request;

    // Byte offset is meaningless without byte enables.
    logic unused_addr;
    assign unused_addr = ^cpu_address[1:0];

    assign request      = cpu_read | cpu_write;
    assign cpu_readdata = rdata_buf;

`ifdef MIPS_DATA_BRIDGE_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             error_nx;
    logic             expired;

    assign expired = (cnt == CNT_LAST);
`else
    logic unused_cfg;
    assign unused_cfg = TIMEOUT_CYCLES[0];
    assign bus_error  = 1'b0;
`endif

    // Next-state and stall logic; every register holds unless a transition updates it.
    always_comb begin
        state_nx       = state;
        address_nx     = bus_address;
        writedata_nx   = bus_writedata;
        read_nx        = bus_read;
        write_nx       = bus_write;
        rdata_nx       = rdata_buf;
        cpu_clk_enable = 1'b1;
`ifdef MIPS_DATA_BRIDGE_TIMEOUT_EN
        cnt_nx         = cnt;
        error_nx       = bus_error;
`endif
        case (state)
            IDLE: begin
                cpu_clk_enable = !request;
                if (request) begin
                    address_nx   = {cpu_address[31:2], 2'b00};
                    writedata_nx = cpu_writedata;
                    write_nx     = cpu_write;
                    read_nx      = cpu_read & !cpu_write;
                    state_nx     = BUS;
`ifdef MIPS_DATA_BRIDGE_TIMEOUT_EN
                    cnt_nx       = '0;
`endif
                end
            end
            BUS: begin
                cpu_clk_enable = 1'b0;
                if (!bus_waitrequest) begin
                    read_nx  = 1'b0;
                    write_nx = 1'b0;
                    if (bus_read) begin
                        rdata_nx = bus_readdata;
                    end
                    state_nx = DONE;
                end
`ifdef MIPS_DATA_BRIDGE_TIMEOUT_EN
                else if (expired) begin
                    // Abort: an abandoned read returns zero and the error sticks.
                    read_nx  = 1'b0;
                    write_nx = 1'b0;
                    if (bus_read) begin
                        rdata_nx = 32'h0000_0000;
                    end
                    error_nx = 1'b1;
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
`endif
            end
            DONE: begin
                // One buffer cycle so the committing request is never re-issued.
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            bus_address   <= '0;
            bus_writedata <= '0;
            bus_read      <= 1'b0;
            bus_write     <= 1'b0;
            rdata_buf     <= '0;
        end else begin
            state         <= state_nx;
            bus_address   <= address_nx;
            bus_writedata <= writedata_nx;
            bus_read      <= read_nx;
            bus_write     <= write_nx;
            rdata_buf     <= rdata_nx;
        end
    end

`ifdef MIPS_DATA_BRIDGE_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            bus_error <= 1'b0;
        end else begin
            cnt       <= cnt_nx;
            bus_error <= error_nx;
        end
    end
`endif

endmodule

// File: tb/tb_mips_data_bus_bridge.sv
// Directed bench for mips_data_bus_bridge: single accesses, priority, back-to-back, reset abort,
// and (with MIPS_DATA_BRIDGE_TIMEOUT_EN) the timeout abort.
module tb_mips_data_bus_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_address;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_writedata;
    logic [31:0] cpu_readdata;
    logic        cpu_clk_enable;
    logic [31:0] bus_address;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_writedata;
    logic        bus_waitrequest;
    logic [31:0] bus_readdata;
    logic        bus_error;

    int n_checks = 0;
    int n_pass   = 0;

    int          obs_stall;
    int          obs_rd;
    int          obs_wr;
    logic [31:0] obs_addr;
    logic [31:0] obs_wdata;
    logic [31:0] obs_rdata;

    mips_data_bus_bridge #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_address    (cpu_address),
        .cpu_read       (cpu_read),
        .cpu_write      (cpu_write),
        .cpu_writedata  (cpu_writedata),
        .cpu_readdata   (cpu_readdata),
        .cpu_clk_enable (cpu_clk_enable),
        .bus_address    (bus_address),
        .bus_read       (bus_read),
        .bus_write      (bus_write),
        .bus_writedata  (bus_writedata),
        .bus_waitrequest(bus_waitrequest),
        .bus_readdata   (bus_readdata),
        .bus_error      (bus_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one CPU access; the slave holds waitrequest for 'waits' strobe cycles.
    task automatic do_access(input string tag, input logic [31:0] addr, input logic rd,
                             input logic wr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int waits);
        int busy = 0;
        bit done = 0;
        cpu_address   = addr;
        cpu_read      = rd;
        cpu_write     = wr;
        cpu_writedata = wdata;
        bus_readdata  = rdata;
        obs_stall = 0; obs_rd = 0; obs_wr = 0;
        obs_addr  = 'x; obs_wdata = 'x;
        #1;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            if (cpu_clk_enable) done = 1;
            else obs_stall++;
            if (bus_read | bus_write) begin
                obs_addr        = bus_address;
                obs_wdata       = bus_writedata;
                obs_rd         += int'(bus_read);
                obs_wr         += int'(bus_write);
                bus_waitrequest = (busy < waits);
                busy++;
            end
            if (done) begin
                obs_rdata = cpu_readdata;
                check({tag, "_done_strobes"}, 32'({bus_read, bus_write}), 32'h0);
            end else begin
                tick();
            end
        end
        check({tag, "_completed"}, 32'(done), 32'h1);
        cpu_read        = 1'b0;
        cpu_write       = 1'b0;
        bus_waitrequest = 1'b0;
        tick();
        check({tag, "_idle_enable"}, 32'(cpu_clk_enable), 32'h1);
    endtask

    initial begin
        int n10 = 0;
        int n14 = 0;
        int first = -1;
        int second = -1;
        int commits = 0;
        int done_strobes = 0;

        reset = 1'b1;
        cpu_address = '0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_writedata = '0;
        bus_waitrequest = 1'b0; bus_readdata = '0;
        tick();
        tick();
        check("rst_bus_read", 32'(bus_read), 32'h0);
        check("rst_bus_write", 32'(bus_write), 32'h0);
        check("rst_bus_address", bus_address, 32'h0);
        check("rst_bus_writedata", bus_writedata, 32'h0);
        check("rst_cpu_readdata", cpu_readdata, 32'h0);
        check("rst_bus_error", 32'(bus_error), 32'h0);
        check("rst_enable_idle", 32'(cpu_clk_enable), 32'h1);
        cpu_read = 1'b1;
        #1;
        check("rst_enable_req", 32'(cpu_clk_enable), 32'h0);
        cpu_read = 1'b0;
        reset = 1'b0;
        tick();

        // Zero-wait read
        do_access("rd0", 32'h0000_1000, 1'b1, 1'b0, 32'h0, 32'hCAFE_F00D, 0);
        check("rd0_stall", 32'(obs_stall), 32'd2);
        check("rd0_read_cycles", 32'(obs_rd), 32'd1);
        check("rd0_write_cycles", 32'(obs_wr), 32'd0);
        check("rd0_address", obs_addr, 32'h0000_1000);
        check("rd0_readdata", obs_rdata, 32'hCAFE_F00D);

        // Unaligned write with three wait states
        do_access("wr3", 32'h0000_2003, 1'b0, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 3);
        check("wr3_stall", 32'(obs_stall), 32'd5);
        check("wr3_write_cycles", 32'(obs_wr), 32'd4);
        check("wr3_read_cycles", 32'(obs_rd), 32'd0);
        check("wr3_address", obs_addr, 32'h0000_2000);
        check("wr3_writedata", obs_wdata, 32'h1234_5678);
        check("wr3_readdata_kept", obs_rdata, 32'hCAFE_F00D);

        // Read and write together: write wins
        do_access("rw", 32'h0000_0040, 1'b1, 1'b1, 32'hA5A5_5A5A, 32'h1111_2222, 0);
        check("rw_write_cycles", 32'(obs_wr), 32'd1);
        check("rw_read_cycles", 32'(obs_rd), 32'd0);
        check("rw_address", obs_addr, 32'h0000_0040);
        check("rw_writedata", obs_wdata, 32'hA5A5_5A5A);
        check("rw_readdata_kept", obs_rdata, 32'hCAFE_F00D);
        check("no_error", 32'(bus_error), 32'h0);

`ifdef MIPS_DATA_BRIDGE_TIMEOUT_EN
        // Slave never answers: abort after four strobe cycles
        do_access("to", 32'h0000_0300, 1'b1, 1'b0, 32'h0, 32'h7777_7777, 100);
        check("to_read_cycles", 32'(obs_rd), 32'd4);
        check("to_stall", 32'(obs_stall), 32'd5);
        check("to_readdata", obs_rdata, 32'h0);
        check("to_error", 32'(bus_error), 32'h1);
        do_access("after_to", 32'h0000_0304, 1'b1, 1'b0, 32'h0, 32'h3333_4444, 0);
        check("after_to_readdata", obs_rdata, 32'h3333_4444);
        check("to_error_sticky", 32'(bus_error), 32'h1);
`endif

        // Back-to-back reads with the request held through commit
        cpu_read = 1'b1; cpu_write = 1'b0; cpu_address = 32'h0000_0010;
        bus_waitrequest = 1'b0; bus_readdata = 32'hA000_0010;
        #1;
        for (int cyc = 0; cyc < 12 && commits < 2; cyc++) begin
            if (bus_read) begin
                if (bus_address == 32'h0000_0010) n10++;
                else if (bus_address == 32'h0000_0014) n14++;
                if (first < 0) first = cyc;
                else second = cyc;
            end
            if (cpu_clk_enable) begin
                done_strobes += int'(bus_read | bus_write);
                commits++;
                if (commits == 1) begin
                    check("b2b_rdata0", cpu_readdata, 32'hA000_0010);
                    cpu_address  = 32'h0000_0014;
                    bus_readdata = 32'hA000_0014;
                end else begin
                    check("b2b_rdata1", cpu_readdata, 32'hA000_0014);
                end
            end
            if (commits < 2) tick();
        end
        cpu_read = 1'b0;
        check("b2b_commits", 32'(commits), 32'd2);
        check("b2b_issue_10", 32'(n10), 32'd1);
        check("b2b_issue_14", 32'(n14), 32'd1);
        check("b2b_first_cycle", 32'(first), 32'd1);
        check("b2b_spacing", 32'(second - first), 32'd3);
        check("b2b_done_strobes", 32'(done_strobes), 32'd0);
        tick();

        // Reset in the second BUS cycle of a waited read
        cpu_read = 1'b1; cpu_address = 32'h0000_0080; bus_waitrequest = 1'b1;
        tick();
        tick();
        check("rstbus_strobe_before", 32'(bus_read), 32'h1);
        reset = 1'b1;
        tick();
        check("rstbus_read", 32'(bus_read), 32'h0);
        check("rstbus_write", 32'(bus_write), 32'h0);
        check("rstbus_readdata", cpu_readdata, 32'h0);
        check("rstbus_address", bus_address, 32'h0);
        check("rstbus_no_done", 32'(cpu_clk_enable), 32'h0);
        check("rstbus_error", 32'(bus_error), 32'h0);
        cpu_read = 1'b0; reset = 1'b0; bus_waitrequest = 1'b0;
        tick();
        check("post_rst_enable", 32'(cpu_clk_enable), 32'h1);
        check("post_rst_read", 32'(bus_read), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_data_bus_bridge.md
# mips_data_bus_bridge

Sits directly downstream of the Harvard CPU's data port. It converts the CPU's combinational-read / single-cycle-write data interface into a registered, waitrequest-style memory bus. While an access is outstanding it stalls the CPU by driving the CPU's `clk_enable` low. Read data is buffered and presented to the CPU in the commit cycle.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles `bus_waitrequest` may hold an access before it is aborted. Only used when the timeout feature is compiled in.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_address`  in  32  CPU `data_address`.
- `cpu_read`  in  1  CPU `data_read`.
- `cpu_write`  in  1  CPU `data_write`.
- `cpu_writedata`  in  32  CPU `data_writedata`.
- `cpu_readdata`  out  32  to CPU `data_readdata`.
- `cpu_clk_enable`  out  1  to CPU `clk_enable`; low stalls the CPU.
- `bus_address`  out  32  word-aligned bus address.
- `bus_read`  out  1  bus read strobe, registered.
- `bus_write`  out  1  bus write strobe, registered.
- `bus_writedata`  out  32  registered write data.
- `bus_waitrequest`  in  1  high means the slave has not yet accepted the access.
- `bus_readdata`  in  32  valid on the edge where `bus_read` is high and `bus_waitrequest` is low.
- `bus_error`  out  1  sticky timeout flag.

## Operation
- FSM with three states: IDLE, BUS, DONE.
- IDLE:
  - `cpu_clk_enable = !(cpu_read | cpu_write)`. This is combinational, so the CPU is stalled in the same cycle it raises a request.
  - On an edge with a request pending:
    - latch `bus_address = {cpu_address[31:2],2'b00}` and `bus_writedata = cpu_writedata`;
    - set `bus_write = cpu_write`;
    - set `bus_read = cpu_read & !cpu_write`;
    - clear the timeout counter;
    - go to BUS.
- Priority: write wins when `cpu_read` and `cpu_write` are both high. The read is dropped and the readdata buffer keeps its previous value.
- Address bits [1:0] are ignored; there are no byte enables.
- BUS:
  - `cpu_clk_enable = 0`; strobes and address stay stable.
  - On an edge with `bus_waitrequest == 0`:
    - clear both strobes;
    - if this was a read, capture `bus_readdata` into the readdata buffer;
    - go to DONE.
  - Otherwise stay in BUS and increment the timeout counter.
- DONE:
  - `cpu_clk_enable = 1`, so the CPU commits its instruction on this edge.
  - Next state is IDLE unconditionally. This single buffer cycle guarantees the same request is never re-issued.
- `cpu_readdata` is the registered readdata buffer at all times. It changes only on a read completion or on reset.
- The request inputs are not sampled in BUS or DONE.

## Timing
- Reset values:
  - FSM in IDLE;
  - `bus_read = 0`, `bus_write = 0`;
  - `bus_address = 0`, `bus_writedata = 0`;
  - readdata buffer = 0, so `cpu_readdata = 0`;
  - `bus_error = 0`, timeout counter = 0.
- With reset high, `cpu_clk_enable` follows the IDLE rule.
- Minimum access with zero wait states:
  - cycle 0: IDLE, stall asserted;
  - cycle 1: BUS, strobe high, `bus_waitrequest` low;
  - cycle 2: DONE, `cpu_readdata` valid, CPU commits.
- The CPU is stalled for 2 cycles plus N, where N is the number of `bus_waitrequest`-high cycles.
- Back-to-back accesses: the next request is seen in the IDLE cycle after DONE. The throughput limit is one access per 3 cycles.
- Reset during BUS:
  - strobes drop on that edge regardless of `bus_waitrequest`;
  - the access is abandoned with no DONE cycle;
  - the slave must tolerate an abandoned strobe.
- Cycles with no request keep the FSM in IDLE with `cpu_clk_enable = 1`.

## Configuration
- `MIPS_DATA_BRIDGE_TIMEOUT_EN` defined:
  - the counter is `$clog2(TIMEOUT_CYCLES+1)` bits wide;
  - abort rule: when `bus_waitrequest` is still high on the edge where the counter equals `TIMEOUT_CYCLES-1`, drop the strobes, go to DONE and set `bus_error` (sticky until reset);
  - an aborted read loads the buffer with `32'h0000_0000`.
- Undefined:
  - no counter is present;
  - BUS waits indefinitely;
  - `bus_error` is tied to 0.

## Test plan
- Reset, then `cpu_read` at 0x1000 with zero wait states and `bus_readdata` = 0xCAFEF00D:
  - `bus_address` = 0x1000;
  - `bus_read` high for exactly 1 cycle;
  - `cpu_clk_enable` low for 2 cycles, then high with `cpu_readdata` = 0xCAFEF00D.
- `cpu_write` at 0x2003 with data 0x12345678 and 3 wait cycles:
  - `bus_address` = 0x2000, `bus_writedata` = 0x12345678;
  - `bus_write` high for 4 cycles;
  - stall lasts 5 cycles;
  - `cpu_readdata` keeps its previous value.
- Read and write asserted together at 0x40:
  - only `bus_write` is issued;
  - `bus_read` stays 0 throughout.
- Reset asserted in the 2nd BUS cycle of a waited read:
  - next cycle shows IDLE with strobes 0 and `cpu_readdata` = 0;
  - no DONE cycle occurs.
- Two consecutive reads (0x10, then 0x14):
  - strobes never stay high across DONE;
  - each address is issued exactly once;
  - accesses are 3 cycles apart.
- With `MIPS_DATA_BRIDGE_TIMEOUT_EN` defined, `TIMEOUT_CYCLES` = 4 and `bus_waitrequest` held high:
  - strobe is high for 4 cycles, then DONE;
  - `bus_error` = 1, `cpu_readdata` = 0;
  - `bus_error` stays 1 until reset.
